// File: rtl/async_fifo_cdc.sv
// rtl/async_fifo_cdc.sv - dual-clock FIFO with Gray-coded pointer crossing
`timescale 1ns/1ps

// Two-flop synchronizer for a Gray-coded pointer entering a new clock domain.
module async_fifo_cdc_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// Dual-clock FIFO: write side in wr_clk, read side in rd_clk, pointers cross as Gray code.
module async_fifo_cdc #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 3
) (
  input  logic                  rd_clk,
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  read_req,
  output logic                  data_out_vld,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_empty,
  input  logic                  data_in_vld,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  fifo_full
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int SLOTS = 1 << AW;

  // Extra pointer bit distinguishes a full ring from an empty one after wrap.
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_W = FIFO_DEPTH[AW:0];

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b = g;
    for (int i = 1; i < PW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [SLOTS];

  // Write-domain state
  logic [AW:0] wr_ptr;
  logic [AW:0] wr_ptr_next;
  logic [AW:0] wr_ptr_gray;
  logic [AW:0] rd_gray_sync;
  logic [AW:0] rd_sync;
  logic [AW:0] wr_occ;
  logic        push;

  // Read-domain state
  logic [AW:0] rd_ptr;
  logic [AW:0] rd_ptr_next;
  logic [AW:0] rd_ptr_gray;
  logic [AW:0] wr_gray_sync;
  logic [AW:0] wr_sync;
  logic        pop;

  // ---------------- write domain ----------------

  assign wr_ptr_next = wr_ptr + PTR_ONE;
  assign rd_sync     = gray2bin(rd_gray_sync);
  // Occupancy seen from the write side; rd_sync lags, so this can only over-estimate.
  assign wr_occ      = wr_ptr - rd_sync;
  assign fifo_full   = (wr_occ >= DEPTH_W);
  assign push        = data_in_vld && !fifo_full;

  // Advance the write pointer and its Gray image together so the crossing value is glitch-free.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
    end else if (push) begin
      wr_ptr      <= wr_ptr_next;
      wr_ptr_gray <= bin2gray(wr_ptr_next);
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge wr_clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  async_fifo_cdc_sync #(.W(PW)) u_rd_ptr_sync (
    .clk (wr_clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rd_gray_sync)
  );

  // ---------------- read domain ----------------

  assign rd_ptr_next = rd_ptr + PTR_ONE;
  assign wr_sync     = gray2bin(wr_gray_sync);
  // wr_sync lags the true write pointer, so empty may linger but never clears early.
  assign fifo_empty  = (rd_ptr == wr_sync);
  assign pop         = read_req && !fifo_empty;

  // Pop one word per accepted request; data_out holds its last value otherwise.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      rd_ptr_gray  <= '0;
      data_out     <= '0;
      data_out_vld <= 1'b0;
    end else begin
      data_out_vld <= pop;
      if (pop) begin
        data_out    <= mem[rd_ptr[AW-1:0]];
        rd_ptr      <= rd_ptr_next;
        rd_ptr_gray <= bin2gray(rd_ptr_next);
      end
    end
  end

  async_fifo_cdc_sync #(.W(PW)) u_wr_ptr_sync (
    .clk (rd_clk),
    .rst (rst),
    .d   (wr_ptr_gray),
    .q   (wr_gray_sync)
  );

endmodule

// File: tb/tb_async_fifo_cdc.sv
// tb/tb_async_fifo_cdc.sv - self-checking bench for async_fifo_cdc
`timescale 1ns/1ps

module tb_async_fifo_cdc;

  localparam int DW    = 32;
  localparam int DEPTH = 3;

  logic          rd_clk;
  logic          wr_clk;
  logic          rst;
  logic          read_req;
  logic          data_out_vld;
  logic [DW-1:0] data_out;
  logic          fifo_empty;
  logic          data_in_vld;
  logic [DW-1:0] data_in;
  logic          fifo_full;

  async_fifo_cdc #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .rd_clk       (rd_clk),
    .wr_clk       (wr_clk),
    .rst          (rst),
    .read_req     (read_req),
    .data_out_vld (data_out_vld),
    .data_out     (data_out),
    .fifo_empty   (fifo_empty),
    .data_in_vld  (data_in_vld),
    .data_in      (data_in),
    .fifo_full    (fifo_full)
  );

  int chk_cnt = 0;
  int err_cnt = 0;
  int pop_cnt = 0;
  logic exp_pop = 1'b0;

  // Reference model: words accepted by the write side and not yet seen on data_out.
  logic [DW-1:0] q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    rd_clk = 1'b0;
    #13;
    forever #10 rd_clk = ~rd_clk;
  end

  // One write-clock cycle of stimulus; the model records the word if the FIFO could take it.
  task automatic wr_cycle(input logic vld, input logic [DW-1:0] val);
    logic acc;
    data_in_vld = vld;
    data_in     = val;
    acc = vld && !fifo_full && !rst;
    @(posedge wr_clk);
    if (acc) q.push_back(val);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() > 0; i++) wr_cycle(1'b0, '0);
    repeat (6) wr_cycle(1'b0, '0);
    check_eq(tag, q.size(), 0);
    check_eq({tag, "_empty"}, fifo_empty, 1'b1);
  endtask

  // A pop is due at the coming rd edge if a request meets a non-empty FIFO.
  always @(negedge rd_clk) exp_pop = read_req && !fifo_empty && !rst;

  // Read-side scoreboard: every word out must be the oldest accepted word.
  always @(posedge rd_clk) begin
    #1;
    check_eq("rd_vld", data_out_vld, exp_pop);
    if (data_out_vld) begin
      pop_cnt++;
      check_eq("rd_model_has_word", q.size() > 0, 1'b1);
      if (q.size() > 0) check_eq("rd_data", data_out, q.pop_front());
    end
    if (!rst && q.size() == 0) check_eq("rd_empty_when_drained", fifo_empty, 1'b1);
  end

  // Write-side invariants: never over capacity, full must show once depth is reached.
  always @(posedge wr_clk) begin
    #1;
    if (!rst) begin
      check_eq("wr_occ_bound", q.size() <= DEPTH, 1'b1);
      if (q.size() >= DEPTH) check_eq("wr_full_at_depth", fifo_full, 1'b1);
    end
  end

  initial begin
    #200000;
    err_cnt++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $fatal(1);
  end

  initial begin
    int cnt;
    int base;
    logic found;

    rst         = 1'b1;
    read_req    = 1'b0;
    data_in_vld = 1'b0;
    data_in     = '0;

    // 1. reset state
    repeat (11) @(posedge wr_clk);
    #1;
    check_eq("t1_empty", fifo_empty, 1'b1);
    check_eq("t1_full", fifo_full, 1'b0);
    check_eq("t1_vld", data_out_vld, 1'b0);
    check_eq("t1_data", data_out, '0);
    rst = 1'b0;
    wr_cycle(1'b0, '0);

    // 2. fill to capacity, overflow push dropped
    wr_cycle(1'b1, 32'd1);
    data_in_vld = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;
    check_eq("t2_empty_clears", fifo_empty, 1'b0);
    @(posedge wr_clk);
    #1;
    wr_cycle(1'b1, 32'd2);
    wr_cycle(1'b1, 32'd3);
    check_eq("t2_full_after3", fifo_full, 1'b1);
    wr_cycle(1'b1, 32'd4);
    check_eq("t2_full_after4", fifo_full, 1'b1);
    wr_cycle(1'b0, '0);

    // 3. drain in order, full clears 2-3 wr_clk after the first pop
    check_eq("t3_full_before", fifo_full, 1'b1);
    read_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge wr_clk);
      #1;
      if (data_out_vld) found = 1'b1;
    end
    check_eq("t3_first_pop_seen", found, 1'b1);
    cnt = 1;
    while (fifo_full && cnt < 10) begin
      @(posedge wr_clk);
      #1;
      cnt++;
    end
    check_eq("t3_full_clear_window", (cnt >= 2 && cnt <= 3), 1'b1);
    for (int i = 0; i < 40 && pop_cnt < 3; i++) wr_cycle(1'b0, '0);
    repeat (4) wr_cycle(1'b0, '0);
    check_eq("t3_pop_count", pop_cnt, 3);
    check_eq("t3_empty", fifo_empty, 1'b1);

    // 4. reads on an empty FIFO do nothing
    repeat (10) wr_cycle(1'b0, '0);
    check_eq("t4_pop_count", pop_cnt, 3);
    check_eq("t4_data_hold", data_out, 32'd3);
    check_eq("t4_empty", fifo_empty, 1'b1);

    // 5. continuous push stream with continuous reads
    for (int v = 1; v <= 4; v++) wr_cycle(1'b1, DW'(v));
    repeat (100) wr_cycle(1'b1, 32'd4);
    data_in_vld = 1'b0;
    drain("t5_drained");

    // 6. reset with two words stored discards them
    read_req = 1'b0;
    wr_cycle(1'b1, 32'h0000_000A);
    wr_cycle(1'b1, 32'h0000_000B);
    repeat (6) wr_cycle(1'b0, '0);
    check_eq("t6_words_visible", fifo_empty, 1'b0);
    rst = 1'b1;
    q.delete();
    repeat (10) wr_cycle(1'b0, '0);
    check_eq("t6_rst_empty", fifo_empty, 1'b1);
    check_eq("t6_rst_full", fifo_full, 1'b0);
    check_eq("t6_rst_vld", data_out_vld, 1'b0);
    check_eq("t6_rst_data", data_out, '0);
    rst = 1'b0;
    wr_cycle(1'b0, '0);
    read_req = 1'b1;
    base = pop_cnt;
    repeat (20) wr_cycle(1'b0, '0);
    check_eq("t6_no_stale_pop", pop_cnt, base);
    check_eq("t6_empty_after", fifo_empty, 1'b1);

    // 7. randomized traffic in both domains
    read_req = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) wr_cycle(1'($urandom_range(0, 1)), $urandom);
      end
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge rd_clk);
          #1;
          read_req = ($urandom_range(0, 2) != 0);
        end
      end
    join
    @(posedge wr_clk);
    #1;
    data_in_vld = 1'b0;
    read_req    = 1'b1;
    drain("t7_drained");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
